conv_sched: RTL
===============

# conv_sched

Layer-level sequencer for the 32×32 systolic convolution array. It splits a layer's filters into column-wide tiles and runs each tile as a weight load followed by a skewed activation stream and an output drain. It generates per-row input enables, per-column output enables and the weight/partial-sum mode select. It sits between the layer command interface and the array plus its weight loader.

## Interface
- ROW, 32, array rows (input lanes)
- COL, 32, array columns (filters per tile)
- PIX_W, 10, width of output-pixel count
- FILT_W, 8, width of filter count
- T_W, 12, width of pass cycle counter; must satisfy 2^T_W > ROW+COL+2^PIX_W
---
- clk  in  1  clock
- nrst  in  1  reset, asynchronous, active-low
- start  in  1  layer start pulse; sampled only in IDLE
- abort  in  1  synchronous abort; returns to IDLE from any state
- cfg_num_filter  in  FILT_W  filters in layer
- cfg_rows  in  6  active rows, 1..ROW
- cfg_num_pix  in  PIX_W  output pixels per tile pass
- stall  in  1  activation source not ready; freezes STREAM/DRAIN
- wload_ack  in  1  weight loader finished current tile (1-cycle pulse)
- wload_req  out  1  request weights for tile_idx
- tile_idx  out  FILT_W  current tile number
- w_ps  out  1  1 = array in weight-load mode, 0 = partial-sum mode
- row_en  out  ROW  per-row input enable
- col_en  out  COL  per-column output valid
- busy  out  1  layer in progress
- done  out  1  1-cycle layer-complete pulse

## Operation
- States: IDLE, WLOAD, STREAM, DRAIN, NEXT, DONE.
- IDLE: on start, latch cfg_* and set tile_idx=0, remaining=cfg_num_filter. If any of cfg_num_filter, cfg_rows or cfg_num_pix is zero, go to DONE. Otherwise go to WLOAD.
- WLOAD: wload_req=1, w_ps=1, t=0. On wload_ack go to STREAM.
- cols = min(COL, remaining), fixed for the tile.
- Window rule: row_en[r] = (t ≥ r) && (t < r+cfg_num_pix) && (r < cfg_rows).
- Window rule: col_en[c] = (t ≥ cfg_rows+c) && (t < cfg_rows+c+cfg_num_pix) && (c < cols).
- STREAM: t increments each non-stalled cycle. Leave for DRAIN after t = cfg_num_pix+cfg_rows−2, the last row_en cycle.
- DRAIN: row_en=0, t continues to increment. Leave for NEXT after t = cfg_rows+cols+cfg_num_pix−2, the last col_en cycle.
- NEXT: remaining −= cols and tile_idx += 1. If remaining reaches 0, go to DONE; else go to WLOAD.
- DONE: done=1, busy=0. Next state is IDLE.
- stall=1 in STREAM/DRAIN: t holds, and row_en and col_en are forced to 0 that cycle.
- abort has priority over every other input. Next state is IDLE, all outputs return to reset values, and done is not pulsed.
- start while busy is ignored. wload_ack outside WLOAD is ignored.
- Changes to cfg_* after start have no effect.

## Timing
- Reset values: state IDLE, all outputs 0, except w_ps=1.
- All outputs are decoded from registered state, t and tile registers; there are no combinational input→output paths.
- Exception: stall masks row_en and col_en in the same cycle. This path is combinational and is documented as such.
- start sampled at cycle 0: busy=1 and wload_req=1 from cycle 1.
- wload_ack at cycle k: STREAM from k+1, with t=0 and row_en[0]=1 in cycle k+1.
- Unstalled pass length, STREAM+DRAIN: cfg_rows+cols+cfg_num_pix−1 cycles, followed by 1 NEXT cycle.
- Last tile: NEXT is followed by DONE, 1 cycle, done=1. IDLE follows.
- Zero-config start: DONE at cycle 1.
- w_ps=1 in IDLE, WLOAD, NEXT and DONE; 0 in STREAM and DRAIN.

## Structure
- conv_sched_pkg holds:
  - the state enum type
  - ROW/COL defaults
  - a function for the minimum T_W
- Sub-module skew_win_mask, parameterised by width N:
  - inputs: t, base offset, length, active count
  - output: enable mask with bit i = (t ≥ base+i) && (t < base+i+len) && (i < count)
  - instantiated twice: rows (base 0) and columns (base cfg_rows)

## Test plan
- Basic single tile: filters=32, rows=9, pix=4, ack 2 cycles after req.
  - row_en[0] high for 4 cycles starting the cycle after ack.
  - row_en[8] high from t=8 to 11.
  - col_en[31] high from t=40 to 43.
  - done exactly 1 cycle after NEXT.
- Partial last tile: filters=40 gives two tiles, with cols=32 then cols=8.
  - Second tile: col_en[31:8] never high.
  - tile_idx shows 0 then 1.
  - wload_req is asserted twice.
- Stall: rows=4, pix=8, stall=1 for 3 cycles at t=5.
  - t holds at 5 during the stall.
  - row_en=0 and col_en=0 during the stall.
  - Pass ends 3 cycles later than unstalled.
- Abort during DRAIN: next cycle IDLE, all outputs at reset values, no done pulse. A new start then runs normally.
- Zero config: filters=0 → done at cycle 1, wload_req never asserted. Repeat with pix=0: same response.
- Reset mid-STREAM: nrst low → outputs at reset values immediately (asynchronous). start during busy ignored (tile_idx unchanged).

Source files
------------

// File: rtl/conv_sched_pkg.sv
// Shared types and constants for the systolic-array layer sequencer.
// Pass-cycle counter sizing helper lives here so integrators can size T_W.
package conv_sched_pkg;

    localparam int ROW_DEF = 32;
    localparam int COL_DEF = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WLOAD,
        S_STREAM,
        S_DRAIN,
        S_NEXT,
        S_DONE
    } state_t;

    // Smallest counter width w with 2^w > rows + cols + 2^pix_w.
    function automatic int min_t_w(input int rows, input int cols, input int pix_w);
        int span;
        int w;
        span = rows + cols + (1 << pix_w);
        w = 1;
        while ((1 << w) <= span) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/conv_sched_skew_win_mask.sv
// Skewed window enable mask: bit i is high while base+i <= t < base+i+len,
// for the first 'count' lanes only.
module skew_win_mask #(
    parameter int N     = 32,
    parameter int T_W   = 12,
    parameter int CNT_W = 6
) (
    input  logic [T_W-1:0]   i_t,
    input  logic [T_W-1:0]   i_base,
    input  logic [T_W-1:0]   i_len,
    input  logic [CNT_W-1:0] i_count,
    output logic [N-1:0]     o_mask
);

    // One extra bit so base+i+len cannot wrap.
    localparam int TW1 = T_W + 1;

    logic [TW1-1:0] w_t_x;
    logic [TW1-1:0] w_base_x;
    logic [TW1-1:0] w_len_x;

    assign w_t_x    = {1'b0, i_t};
    assign w_base_x = {1'b0, i_base};
    assign w_len_x  = {1'b0, i_len};

    always_comb begin
        o_mask = '0;
        for (int i = 0; i < N; i++) begin
            if ((i < int'(i_count)) &&
                (w_t_x >= w_base_x + TW1'(i)) &&
                (w_t_x <  w_base_x + TW1'(i) + w_len_x)) begin
                o_mask[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/conv_sched.sv
// Layer sequencer for the systolic convolution array: splits filters into
// column-wide tiles, each run as weight load, skewed stream and drain.
module conv_sched
    import conv_sched_pkg::*;
#(
    parameter int ROW    = ROW_DEF,
    parameter int COL    = COL_DEF,
    parameter int PIX_W  = 10,
    parameter int FILT_W = 8,
    parameter int T_W    = 12
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    input  logic              abort,
    input  logic [FILT_W-1:0] cfg_num_filter,
    input  logic [5:0]        cfg_rows,
    input  logic [PIX_W-1:0]  cfg_num_pix,
    input  logic              stall,
    input  logic              wload_ack,
    output logic              wload_req,
    output logic [FILT_W-1:0] tile_idx,
    output logic              w_ps,
    output logic [ROW-1:0]    row_en,
    output logic [COL-1:0]    col_en,
    output logic              busy,
    output logic              done
);

    localparam int COLS_W = $clog2(COL + 1);

    state_t            r_state;
    logic [T_W-1:0]    r_t;
    logic [FILT_W-1:0] r_tile_idx;
    logic [FILT_W-1:0] r_remaining;
    logic [5:0]        r_rows;
    logic [PIX_W-1:0]  r_pix;
    logic              r_wload_req;
    logic              r_w_ps;
    logic              r_busy;
    logic              r_done;

    logic [COLS_W-1:0] w_cols;
    logic [T_W-1:0]    w_rows_t;
    logic [T_W-1:0]    w_pix_t;
    logic [T_W-1:0]    w_stream_end;
    logic [T_W-1:0]    w_drain_end;
    logic              w_cfg_zero;
    logic              w_last_tile;
    logic              w_accept;
    logic [ROW-1:0]    w_row_mask;
    logic [COL-1:0]    w_col_mask;

    assign w_cols       = (r_remaining >= FILT_W'(COL)) ? COLS_W'(COL) : COLS_W'(r_remaining);
    assign w_rows_t     = T_W'(r_rows);
    assign w_pix_t      = T_W'(r_pix);
    assign w_stream_end = w_pix_t + w_rows_t - T_W'(2);
    assign w_drain_end  = w_rows_t + T_W'(w_cols) + w_pix_t - T_W'(2);
    assign w_last_tile  = (r_remaining == FILT_W'(w_cols));
    assign w_cfg_zero   = (cfg_num_filter == '0) || (cfg_rows == '0) || (cfg_num_pix == '0);
    assign w_accept     = (r_state == S_IDLE) && start && !abort;

    // Layer configuration is captured once per start and held for the layer.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_rows <= cfg_rows;
            r_pix  <= cfg_num_pix;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state     <= S_IDLE;
            r_t         <= '0;
            r_tile_idx  <= '0;
            r_remaining <= '0;
            r_wload_req <= 1'b0;
            r_w_ps      <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else if (abort) begin
            r_state     <= S_IDLE;
            r_t         <= '0;
            r_tile_idx  <= '0;
            r_remaining <= '0;
            r_wload_req <= 1'b0;
            r_w_ps      <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_tile_idx  <= '0;
                        r_remaining <= cfg_num_filter;
                        r_t         <= '0;
                        if (w_cfg_zero) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state     <= S_WLOAD;
                            r_wload_req <= 1'b1;
                            r_busy      <= 1'b1;
                        end
                    end
                end
                S_WLOAD: begin
                    r_t <= '0;
                    if (wload_ack) begin
                        r_state     <= S_STREAM;
                        r_wload_req <= 1'b0;
                        r_w_ps      <= 1'b0;
                    end
                end
                S_STREAM: begin
                    if (!stall) begin
                        r_t <= r_t + T_W'(1);
                        if (r_t == w_stream_end) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!stall) begin
                        if (r_t == w_drain_end) begin
                            r_state <= S_NEXT;
                            r_w_ps  <= 1'b1;
                        end else begin
                            r_t <= r_t + T_W'(1);
                        end
                    end
                end
                S_NEXT: begin
                    r_remaining <= r_remaining - FILT_W'(w_cols);
                    r_tile_idx  <= r_tile_idx + FILT_W'(1);
                    r_t         <= '0;
                    if (w_last_tile) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state     <= S_WLOAD;
                        r_wload_req <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    skew_win_mask #(
        .N     (ROW),
        .T_W   (T_W),
        .CNT_W (6)
    ) u_row_win (
        .i_t     (r_t),
        .i_base  ('0),
        .i_len   (w_pix_t),
        .i_count (r_rows),
        .o_mask  (w_row_mask)
    );

    skew_win_mask #(
        .N     (COL),
        .T_W   (T_W),
        .CNT_W (COLS_W)
    ) u_col_win (
        .i_t     (r_t),
        .i_base  (w_rows_t),
        .i_len   (w_pix_t),
        .i_count (w_cols),
        .o_mask  (w_col_mask)
    );

    // stall gates the enables combinationally so the array sees no lane
    // activity in the very cycle the source is not ready.
    assign row_en = ((r_state == S_STREAM) && !stall) ? w_row_mask : '0;
    assign col_en = (((r_state == S_STREAM) || (r_state == S_DRAIN)) && !stall) ? w_col_mask : '0;

    assign wload_req = r_wload_req;
    assign tile_idx  = r_tile_idx;
    assign w_ps      = r_w_ps;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
